// File: rtl/mul_iter_pkg.sv
// Shared definitions for the iterative limb multiplier.
//   state_e     : controller states
//   limb_count  : number of L-bit limbs in a W-bit operand
//   clog2_min1  : ceil(log2(v)) clamped to at least 1, used for counter widths
package mul_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic int limb_count(input int w, input int l);
        return w / l;
    endfunction

    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mul_limb.sv
// Combinational unsigned L x L -> 2L limb multiplier.
//   a_i : L-bit unsigned limb
//   b_i : L-bit unsigned limb
//   p_o : 2L-bit unsigned product
module mul_limb #(
    parameter int L = 32
) (
    input  logic [L-1:0]   a_i,
    input  logic [L-1:0]   b_i,
    output logic [2*L-1:0] p_o
);

    assign p_o = (2*L)'(a_i) * (2*L)'(b_i);

endmodule

// File: rtl/mul_iter_limb.sv
// Iterative W x W multiplier. Operands are split into L-bit limbs and one
// L x L partial product is shifted and accumulated per cycle. Signed operands
// are converted to magnitudes on accept and the sign is reapplied at the end.
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, signed_mode)
//   a, b                 : W-bit operands
//   signed_mode          : 1 = two's-complement operands, 0 = unsigned
//   out_valid / out_ready: result handshake
//   result               : 2W-bit product, held until the next computation ends
//   busy                 : high whenever the controller is not idle
module mul_iter_limb
    import mul_iter_pkg::*;
#(
    parameter int W = 64,
    parameter int L = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           signed_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] result,
    output logic           busy
);

    localparam int N  = limb_count(W, L);
    localparam int NN = N * N;
    localparam int CW = clog2_min1(NN);

    generate
        if ((W % L) != 0 || L < 2) begin : g_bad_params
            $fatal(1, "mul_iter_limb: W must be a multiple of L and L must be >= 2");
        end
    endgenerate

    state_e           state_q;
    logic [W-1:0]     a_mag_q;
    logic [W-1:0]     b_mag_q;
    logic             neg_q;
    logic [2*W-1:0]   acc_q;
    logic [2*W-1:0]   res_q;
    logic [CW-1:0]    k_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             in_ready_q;

    logic [W-1:0]     a_mag_d;
    logic [W-1:0]     b_mag_d;
    logic             neg_d;
    logic             zero_d;
    logic [L-1:0]     a_limb;
    logic [L-1:0]     b_limb;
    logic [2*L-1:0]   pp;
    logic [2*W-1:0]   acc_d;
    int               idx_a;
    int               idx_b;
    int               shamt;

    // Magnitude of the most negative value is 2^(W-1), which still fits in
    // W unsigned bits, so negation never overflows here.
    always_comb begin
        a_mag_d = (signed_mode && a[W-1]) ? (~a + W'(1)) : a;
        b_mag_d = (signed_mode && b[W-1]) ? (~b + W'(1)) : b;
        zero_d  = (a == '0) || (b == '0);
        // A zero product is never negated, so the sign is dropped on early exit.
        neg_d   = signed_mode && (a[W-1] ^ b[W-1]) && !zero_d;
    end

    // Counter k walks the a-limbs in the outer loop and b-limbs in the inner.
    always_comb begin
        idx_a  = int'(k_q) / N;
        idx_b  = int'(k_q) % N;
        shamt  = (idx_a + idx_b) * L;
        a_limb = a_mag_q[idx_a*L +: L];
        b_limb = b_mag_q[idx_b*L +: L];
    end

    mul_limb #(
        .L (L)
    ) u_mul_limb (
        .a_i (a_limb),
        .b_i (b_limb),
        .p_o (pp)
    );

    assign acc_d = acc_q + ((2*W)'(pp) << shamt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_mag_q     <= '0;
            b_mag_q     <= '0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            res_q       <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_mag_q    <= a_mag_d;
                        b_mag_q    <= b_mag_d;
                        neg_q      <= neg_d;
                        acc_q      <= '0;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= zero_d ? FIX : CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + CW'(1);
                    if (k_q == CW'(NN - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    res_q       <= neg_q ? (~acc_q + (2*W)'(1)) : acc_q;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    // Returning to IDLE here means no accept can coincide
                    // with the cycle the result is consumed.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = res_q;

endmodule

// File: tb/tb_mul_iter_limb.sv
module tb_mul_iter_limb;

    localparam int W = 64;
    localparam int L = 32;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           signed_mode;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] result;
    logic           busy;

    int checks = 0;
    int errors = 0;

    mul_iter_limb #(
        .W (W),
        .L (L)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference product from plain wide arithmetic.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
        logic signed [2*W-1:0] sx;
        logic signed [2*W-1:0] sy;
        logic [2*W-1:0] ux;
        logic [2*W-1:0] uy;
        if (sm) begin
            sx = $signed({{W{x[W-1]}}, x});
            sy = $signed({{W{y[W-1]}}, y});
            return sx * sy;
        end
        ux = {{W{1'b0}}, x};
        uy = {{W{1'b0}}, y};
        return ux * uy;
    endfunction

    // Invariant on entry/exit: time is 1 unit after a rising edge, DUT idle.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic sm, input int hold);
        logic [2*W-1:0] exp_res;
        logic [2*W-1:0] held;
        int exp_lat;
        int edges;
        int busy_cnt;
        exp_res = model(xa, xb, sm);
        exp_lat = (xa == '0 || xb == '0) ? 1 : (W/L)*(W/L) + 1;
        chk("in_ready_idle", {127'b0, in_ready}, 128'd1);
        a = xa; b = xb; signed_mode = sm; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        edges = 0; busy_cnt = 0;
        while (!out_valid && edges < 100) begin
            if (busy) busy_cnt++;
            // Inputs are ignored while busy; scramble them.
            a = W'({$urandom, $urandom}); b = W'({$urandom, $urandom});
            signed_mode = 1'($urandom); in_valid = 1'($urandom);
            @(posedge clk); #1;
            edges++;
        end
        if (busy) busy_cnt++;
        chk("latency", 128'(edges), 128'(exp_lat));
        chk("result", result, exp_res);
        chk("in_ready_done", {127'b0, in_ready}, 128'd0);
        held = result;
        for (int c = 0; c < hold; c++) begin
            a = W'({$urandom, $urandom}); b = W'({$urandom, $urandom});
            in_valid = 1'($urandom);
            @(posedge clk); #1;
            chk("hold_result", result, held);
            chk("hold_valid", {127'b0, out_valid}, 128'd1);
            chk("hold_in_ready", {127'b0, in_ready}, 128'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("busy_cycles", 128'(busy_cnt), 128'(exp_lat + 1));
        chk("post_valid", {127'b0, out_valid}, 128'd0);
        chk("post_in_ready", {127'b0, in_ready}, 128'd1);
        chk("post_result", result, held);
        $display("op a=%h b=%h sm=%0d result=%h exp=%h lat=%0d", xa, xb, sm, held, exp_res, edges);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] min_neg;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; signed_mode = 1'b0;
        min_neg = {1'b1, {(W-1){1'b0}}};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
        chk("rst_busy", {127'b0, busy}, 128'd0);
        chk("rst_in_ready", {127'b0, in_ready}, 128'd1);
        chk("rst_result", result, 128'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op({W{1'b1}}, {W{1'b1}}, 1'b0, 0);
        chk("umax_const", result, 128'hFFFFFFFF_FFFFFFFE_00000000_00000001);
        run_op(-64'sd3, 64'd7, 1'b1, 0);
        chk("mixed_const", result, {{120{1'b1}}, 8'hEB});
        run_op(min_neg, min_neg, 1'b1, 0);
        chk("smin_const", result, 128'h40000000_00000000_00000000_00000000);
        run_op(min_neg, min_neg, 1'b0, 0);
        chk("umin_const", result, 128'h40000000_00000000_00000000_00000000);
        run_op(64'd0, 64'h1234, 1'b1, 0);
        run_op(-64'sd1, 64'd0, 1'b1, 2);
        run_op({W{1'b1}}, 64'h0123_4567_89AB_CDEF, 1'b0, 10);

        // Reset in the middle of CALC (after k = 0 and k = 1 have been taken)
        a = 64'hDEAD_BEEF_0000_0001; b = 64'h0000_0003_0000_0005; signed_mode = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {127'b0, out_valid}, 128'd0);
        chk("midrst_result", result, 128'd0);
        chk("midrst_busy", {127'b0, busy}, 128'd0);
        chk("midrst_in_ready", {127'b0, in_ready}, 128'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(64'd5, 64'd6, 1'b0, 0);
        chk("after_rst_30", result, 128'd30);

        // Randomized operations with corner-biased operands
        for (int t = 0; t < 40; t++) begin
            ra = W'({$urandom, $urandom});
            rb = W'({$urandom, $urandom});
            case ($urandom_range(0, 7))
                0: ra = '0;
                1: rb = min_neg;
                2: ra = {W{1'b1}};
                3: rb = W'($urandom_range(0, 15));
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_iter_limb.md
Name: mul_iter_limb

Overview:
- Parametrised, iterative W×W multiplier producing a 2W-bit product.
- Operands split into L-bit limbs; one L×L partial product per cycle, shifted and accumulated into a 2W-bit register.
- Adds signed/unsigned mode per transaction, valid/ready handshakes and a zero-operand early exit.
- Sits on the datapath wherever a full-width product is needed but a full-array multiplier is too large.

Parameters:
- W, 64, operand width; must be a multiple of L.
- L, 32, limb width (≥2); N = W/L limbs, N*N partial products per operation.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and mode valid
- in_ready  out  1  block can accept operands
- a  in  W  multiplicand
- b  in  W  multiplier
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with a/b
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  2W  product
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset state:
  - state = IDLE; accumulator, result and limb counter = 0.
  - out_valid = 0, busy = 0, in_ready = 1.
  - Reset mid-operation abandons the operation; no partial result is ever presented.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture magnitudes |a|, |b| (only when signed_mode = 1; otherwise raw values) and neg = signed_mode & (a[W-1] ^ b[W-1]).
  - Clear the accumulator and counter.
  - Go to CALC, or go directly to FIX if either operand is zero (early exit).
- Magnitude rule: -2^(W-1) has magnitude 2^(W-1), which fits unsigned in W bits; no overflow.
- CALC:
  - One partial product per edge, for counter k = 0 .. N*N-1: i = k / N (a-limb), j = k % N (b-limb).
  - acc += (a_limb[i] * b_limb[j]) << ((i+j)*L).
  - Accumulation is 2W bits wide; the final sum cannot exceed 2W bits.
  - After k = N*N-1, go to FIX.
- FIX:
  - result = neg ? (~acc + 1) : acc, truncated to 2W bits.
  - When the early exit is taken, result = 0 regardless of neg.
  - Go to DONE.
- DONE:
  - out_valid = 1; result is held stable while out_valid & !out_ready.
  - On out_ready, go to IDLE and deassert out_valid.
  - result keeps its last value until the next FIX.
- Latency, counted from the accepting edge:
  - Normal path: out_valid high after N*N+1 further edges (W=64, L=32: 5 edges).
  - Early exit: out_valid high after 1 further edge.
- in_ready is 0 in CALC, FIX and DONE. No new operand is accepted in the same cycle a result is consumed; the next accept is possible from the following IDLE cycle.
- Inputs a, b and signed_mode are ignored outside IDLE. Changing them during CALC has no effect.
- in_valid while busy: held by the producer, per the handshake; it is not an error.
- Counter width: clog2(N*N), minimum 1. N = 1 degenerates to a single CALC cycle.
- Elaboration check: W % L == 0 and L ≥ 2; otherwise a fatal elaboration error.

Decomposition:
- Shared package mul_iter_pkg:
  - state enum (IDLE, CALC, FIX, DONE)
  - limb-count function N(W, L)
  - counter-width function clog2
- Sub-module mul_limb: combinational L×L → 2L unsigned limb multiplier, one instance. Its implementation style is independent of the controller.
- Controller, magnitude/sign logic and accumulator stay in mul_iter_limb.

Test Plan (W=64, L=32):
- Unsigned max:
  - Stimulus: a = b = 0xFFFFFFFF_FFFFFFFF, signed_mode = 0.
  - Response: result = 0xFFFFFFFF_FFFFFFFE_00000000_00000001; out_valid high exactly 5 edges after accept.
- Signed mixed:
  - Stimulus: a = -3 (0xFFFF...FFFD), b = 7, signed_mode = 1.
  - Response: result = -21 = 0xFFFF...FFEB (128-bit).
- Signed extremes:
  - Stimulus: a = b = 0x80000000_00000000, signed_mode = 1.
  - Response: result = 0x40000000_00000000_00000000_00000000.
  - Same operands with signed_mode = 0: result = 2^126 (identical bits).
- Early exit:
  - Stimulus: a = 0, b = 0x1234, signed_mode = 1.
  - Response: result = 0; out_valid after 1 edge; busy high for 2 cycles.
- Backpressure:
  - Stimulus: out_ready held 0 for 10 cycles after out_valid; toggle a/b/in_valid meanwhile.
  - Response: result stable, in_ready = 0, no new accept. After out_ready = 1: one cycle later in_ready = 1 and out_valid = 0.
- Reset mid-operation:
  - Stimulus: assert rst_n = 0 at CALC k = 2; release; then a = 5, b = 6.
  - Response: out_valid = 0 and result = 0 immediately on reset assertion; next result = 30 with normal latency.
